tsc_multicycle_ctrl: RTL

Multi-cycle control FSM for the TSC CPU. Sequences the shared datapath (PC, register file, ALU, unified memory port) through IF/ID/EX/MEM/WB phases per instruction, driving all mux selects and write enables. Owns the memory request handshake, the retired-instruction counter (`num_inst`) and the halt state. Sits between the IR/branch-condition outputs of the datapath and every datapath control input.

---
 rtl/tsc_ctrl_pkg.sv | 27 ++
 rtl/tsc_ctrl_decode.sv | 23 ++
 rtl/tsc_multicycle_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/tsc_ctrl_pkg.sv
// tsc_ctrl_pkg: shared state, instruction class, ALU/PC-source encodings and TSC opcode/func constants
package tsc_ctrl_pkg;
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_WWD, C_HALT, C_ILLEGAL
    } iclass_t;
    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_LHI    = 3'd2;
    localparam logic [2:0] ALU_CMP_EQ = 3'd3;
    localparam logic [2:0] ALU_CMP_NE = 3'd4;
    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_RTYPE = 4'd15;
    localparam logic [5:0] F_ADD = 6'd0;
    localparam logic [5:0] F_SUB = 6'd1;
    localparam logic [5:0] F_WWD = 6'd28;
    localparam logic [5:0] F_HLT = 6'd29;
endpackage

// File: rtl/tsc_ctrl_decode.sv
// tsc_ctrl_decode: combinational opcode/func -> instruction class (in: opcode, func; out: iclass)
module tsc_ctrl_decode
    import tsc_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [5:0] func,
    output iclass_t    iclass
);
    always_comb begin
        iclass = C_ILLEGAL;
        case (opcode)
            OP_BNE, OP_BEQ: iclass = C_BRANCH;
            OP_ADI, OP_LHI: iclass = C_IALU;
            OP_LWD:         iclass = C_LOAD;
            OP_SWD:         iclass = C_STORE;
            OP_JMP:         iclass = C_JUMP;
            OP_RTYPE:       iclass = (func == F_ADD || func == F_SUB) ? C_RALU :
                                     (func == F_WWD) ? C_WWD :
                                     (func == F_HLT) ? C_HALT : C_ILLEGAL;
            default: ;
        endcase
    end
endmodule

// File: rtl/tsc_multicycle_ctrl.sv
// tsc_multicycle_ctrl: IF/ID/EX/MEM/WB control FSM (in: cpu_enable, opcode, func, bcond, mem_ack; out: memory handshake, datapath selects/enables, halted, num_inst)
module tsc_multicycle_ctrl
    import tsc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_cpu,
    input  logic             cpu_enable,
    input  logic [3:0]       opcode,
    input  logic [5:0]       func,
    input  logic             bcond,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             wb_src,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic             wwd_strobe,
    output logic             halted,
    output logic [CNT_W-1:0] num_inst
);
    state_t  state;
    iclass_t ic;
    logic    pend;
    logic    run, in_if, in_id, in_ex, in_mem, in_wb, if_req, jmp, br, br_take, retire;

    tsc_ctrl_decode u_dec (.opcode(opcode), .func(func), .iclass(ic));

    // reset gates every output combinationally so they drop without waiting for a clock
    assign run     = !reset_cpu;
    assign in_if   = run && state == S_IF;
    assign in_id   = run && state == S_ID;
    assign in_ex   = run && state == S_EX;
    assign in_mem  = run && state == S_MEM;
    assign in_wb   = run && state == S_WB;
    // once raised, a fetch request is held until ack regardless of cpu_enable
    assign if_req  = in_if && (cpu_enable || pend);
    assign jmp     = in_id && ic == C_JUMP;
    assign br      = in_ex && ic == C_BRANCH;
    assign br_take = br && bcond;

    assign mem_req      = if_req || in_mem;
    assign mem_we       = in_mem && ic == C_STORE;
    assign mem_addr_src = in_mem;
    assign ir_write     = if_req && mem_ack;
    assign pc_write     = ir_write || jmp || br_take;
    assign pc_src       = jmp ? PC_JMP : br ? PC_BR : PC_INC;
    assign reg_write    = in_wb;
    assign reg_dst      = in_wb && ic == C_RALU;
    assign wb_src       = in_wb && ic == C_LOAD;
    assign alu_src_b    = in_ex && (ic == C_IALU || ic == C_LOAD || ic == C_STORE);
    assign alu_op       = !in_ex ? ALU_ADD :
                          (ic == C_RALU && func == F_SUB) ? ALU_SUB :
                          (ic == C_IALU && opcode == OP_LHI) ? ALU_LHI :
                          (ic == C_BRANCH) ? ((opcode == OP_BEQ) ? ALU_CMP_EQ : ALU_CMP_NE) : ALU_ADD;
    assign wwd_strobe   = in_ex && ic == C_WWD;
    assign halted       = run && state == S_HALT;
    assign retire       = (in_id && (ic == C_JUMP || ic == C_ILLEGAL)) ||
                          (in_ex && (ic == C_BRANCH || ic == C_WWD)) ||
                          (in_mem && ic == C_STORE && mem_ack) || in_wb;

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            state    <= S_IF;
            pend     <= 1'b0;
            num_inst <= '0;
        end else begin
            pend     <= if_req && !mem_ack;
            num_inst <= num_inst + CNT_W'(retire);
            case (state)
                S_IF:    if (ir_write) state <= S_ID;
                S_ID:    state <= (ic == C_HALT) ? S_HALT :
                                  (ic == C_JUMP || ic == C_ILLEGAL) ? S_IF : S_EX;
                S_EX:    state <= (ic == C_LOAD || ic == C_STORE) ? S_MEM :
                                  (ic == C_RALU || ic == C_IALU) ? S_WB : S_IF;
                S_MEM:   if (mem_ack) state <= (ic == C_LOAD) ? S_WB : S_IF;
                S_WB:    state <= S_IF;
                S_HALT:  state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end
endmodule
